// File: rtl/joypad_device.sv
// joypad_device: NES-style controller front end. Debounces eight raw buttons,
// latches them into a shift register on the host latch strobe, and shifts them
// out LSB-first on host clock rises, with fill bits once the eight are gone.
module joypad_device #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          DATA_ACTIVE_LOW = 1'b1,
  parameter bit          FILL_BIT        = 1'b1
) (
  input  logic       clk_in,
  input  logic       nrst_in,
  input  logic [7:0] btn_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  output logic       jp_data_out,
  output logic [7:0] btn_state_out,
  output logic [3:0] read_cnt_out,
  output logic [1:0] state_out
);

  localparam int unsigned NBTN  = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned RC_W  = 4;

  // Counter value on which a differing raw value has been seen DEBOUNCE_CYCLES times
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(7);
  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(8);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic [1:0]       latch_sync_q;
  logic [1:0]       jclk_sync_q;
  logic             jclk_prev_q;
  logic [NBTN-1:0]  btn_s0_q;
  logic [NBTN-1:0]  btn_s1_q;
  logic [CNT_W-1:0] db_cnt_q [NBTN];
  logic [NBTN-1:0]  stable_q;
  logic [NBTN-1:0]  sreg_q;
  logic [RC_W-1:0]  read_cnt_q;
  state_e           state_q;
  logic             latch_s;
  logic             clk_rise_c;

  // Reset synchronizer: asserts asynchronously, releases on the second clk_in edge
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Two-flop synchronizers for all asynchronous host and button inputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync_q <= 2'b00;
      jclk_sync_q  <= 2'b00;
      btn_s0_q     <= '0;
      btn_s1_q     <= '0;
    end else begin
      latch_sync_q <= {latch_sync_q[0], jp_latch_in};
      jclk_sync_q  <= {jclk_sync_q[0], jp_clk_in};
      btn_s0_q     <= btn_in;
      btn_s1_q     <= btn_s0_q;
    end
  end

  assign latch_s = latch_sync_q[1];

  // Registered copy of the synced host clock for one-cycle rise detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      jclk_prev_q <= 1'b0;
    end else begin
      jclk_prev_q <= jclk_sync_q[1];
    end
  end

  assign clk_rise_c = jclk_sync_q[1] & ~jclk_prev_q;

  // Per-button debounce: accept a new value after it differs for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        db_cnt_q[i] <= '0;
      end
      stable_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (btn_s1_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          stable_q[i] <= btn_s1_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Read FSM with shift register and bit counter; a high latch overrides any shift
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      read_cnt_q <= '0;
    end else if (latch_s) begin
      state_q    <= ST_LOAD;
      sreg_q     <= stable_q;
      read_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_LOAD: begin
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (clk_rise_c) begin
            sreg_q     <= {FILL_BIT, sreg_q[NBTN-1:1]};
            read_cnt_q <= read_cnt_q + RC_W'(1);
            if (read_cnt_q == RC_LAST) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (clk_rise_c) begin
            sreg_q     <= {FILL_BIT, sreg_q[NBTN-1:1]};
            read_cnt_q <= RC_MAX;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Data line is the shift register LSB, polarity fixed at elaboration
  assign jp_data_out   = sreg_q[0] ^ DATA_ACTIVE_LOW;
  assign btn_state_out = stable_q;
  assign read_cnt_out  = read_cnt_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_joypad_device.sv
// tb_joypad_device: drives host-protocol reads and button patterns and checks
// against a shift-out model derived from the button order and fill rules.
module tb_joypad_device;

  localparam int unsigned DEB  = 16;
  localparam bit          ALOW = 1'b1;
  localparam bit          FILL = 1'b1;
  localparam int unsigned SETTLE = DEB + 6;

  logic       clk_in;
  logic       nrst_in;
  logic [7:0] btn_in;
  logic       jp_latch_in;
  logic       jp_clk_in;
  logic       jp_data_out;
  logic [7:0] btn_state_out;
  logic [3:0] read_cnt_out;
  logic [1:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  joypad_device #(
    .DEBOUNCE_CYCLES(DEB),
    .DATA_ACTIVE_LOW(ALOW),
    .FILL_BIT       (FILL)
  ) dut (
    .clk_in       (clk_in),
    .nrst_in      (nrst_in),
    .btn_in       (btn_in),
    .jp_latch_in  (jp_latch_in),
    .jp_clk_in    (jp_clk_in),
    .jp_data_out  (jp_data_out),
    .btn_state_out(btn_state_out),
    .read_cnt_out (read_cnt_out),
    .state_out    (state_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: k-th bit on the line after a latch (k = rises seen since the latch)
  function automatic logic exp_line(input logic [7:0] v, input int k);
    logic b;
    b = (k < 8) ? v[k] : FILL;
    return ALOW ? ~b : b;
  endfunction

  function automatic logic [3:0] exp_cnt(input int k);
    return (k > 8) ? 4'd8 : 4'(k);
  endfunction

  function automatic logic [1:0] exp_state(input int k);
    return (k >= 8) ? 2'd3 : 2'd2;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Host drivers: rise then wait the allowed 3-cycle latency; fall completes the phase
  task automatic latch_hi();
    jp_latch_in = 1'b1;
    wait_cyc(3);
  endtask

  task automatic latch_lo();
    wait_cyc(1);
    jp_latch_in = 1'b0;
    wait_cyc(4);
  endtask

  task automatic jclk_hi();
    jp_clk_in = 1'b1;
    wait_cyc(3);
  endtask

  task automatic jclk_lo();
    wait_cyc(1);
    jp_clk_in = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_reset();
    nrst_in     = 1'b0;
    btn_in      = 8'($urandom);
    jp_latch_in = 1'b0;
    jp_clk_in   = 1'b0;
    wait_cyc(4);
    n_checks++;
    if (jp_data_out !== (ALOW ? 1'b1 : 1'b0)) begin
      n_fail++; $display("FAIL reset_data got %b exp %b", jp_data_out, ALOW);
    end
    n_checks++;
    if (btn_state_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_btn got %h exp 00", btn_state_out);
    end
    n_checks++;
    if (read_cnt_out !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d exp 0", read_cnt_out);
    end
    n_checks++;
    if (state_out !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got %0d exp 0", state_out);
    end
    btn_in = 8'h00;
    nrst_in = 1'b1;
    wait_cyc(SETTLE);
    n_checks++;
    if (state_out !== 2'd0) begin
      n_fail++; $display("FAIL post_reset_state got %0d exp 0", state_out);
    end
  endtask

  task automatic test_a_start_read();
    logic [7:0] lvl;
    lvl = 8'b1111_0110;  // expected line levels, element k = after k rises
    btn_in = 8'h09;
    wait_cyc(20);
    n_checks++;
    if (btn_state_out !== 8'h09) begin
      n_fail++; $display("FAIL ast_btn got %h exp 09", btn_state_out);
    end
    latch_hi();
    n_checks++;
    if (jp_data_out !== lvl[0]) begin
      n_fail++; $display("FAIL ast_latch_data got %b exp %b", jp_data_out, lvl[0]);
    end
    latch_lo();
    for (int k = 1; k <= 10; k++) begin
      jclk_hi();
      n_checks++;
      if (jp_data_out !== ((k < 8) ? lvl[k] : 1'b0)) begin
        n_fail++; $display("FAIL ast_data k=%0d got %b exp %b", k, jp_data_out, (k < 8) ? lvl[k] : 1'b0);
      end
      jclk_lo();
      n_checks++;
      if (read_cnt_out !== exp_cnt(k)) begin
        n_fail++; $display("FAIL ast_cnt k=%0d got %0d exp %0d", k, read_cnt_out, exp_cnt(k));
      end
      n_checks++;
      if (state_out !== exp_state(k)) begin
        n_fail++; $display("FAIL ast_state k=%0d got %0d exp %0d", k, state_out, exp_state(k));
      end
    end
  endtask

  task automatic test_debounce();
    logic [7:0] base;
    base = 8'h00;
    btn_in = base;
    wait_cyc(SETTLE);
    for (int c = 0; c < 100; c++) begin
      btn_in[4] = ((c / 5) % 2) == 1;
      wait_cyc(1);
      n_checks++;
      if (btn_state_out[4] !== 1'b0) begin
        n_fail++; $display("FAIL deb_glitch c=%0d got %b exp 0", c, btn_state_out[4]);
      end
    end
    btn_in[4] = 1'b1;
    wait_cyc(17);
    n_checks++;
    if (btn_state_out !== 8'h10) begin
      n_fail++; $display("FAIL deb_accept got %h exp 10", btn_state_out);
    end
  endtask

  task automatic test_random_reads();
    logic [7:0] v;
    int np;
    for (int r = 0; r < 6; r++) begin
      v = 8'($urandom);
      np = int'($urandom_range(0, 11));
      btn_in = v;
      wait_cyc(SETTLE);
      n_checks++;
      if (btn_state_out !== v) begin
        n_fail++; $display("FAIL rnd_btn r=%0d got %h exp %h", r, btn_state_out, v);
      end
      latch_hi();
      n_checks++;
      if (jp_data_out !== exp_line(v, 0) || state_out !== 2'd1 || read_cnt_out !== 4'd0) begin
        n_fail++; $display("FAIL rnd_load r=%0d got d%b s%0d c%0d exp d%b s1 c0",
                           r, jp_data_out, state_out, read_cnt_out, exp_line(v, 0));
      end
      latch_lo();
      for (int k = 1; k <= np; k++) begin
        jclk_hi();
        jclk_lo();
        n_checks++;
        if (jp_data_out !== exp_line(v, k) || read_cnt_out !== exp_cnt(k) || state_out !== exp_state(k)) begin
          n_fail++; $display("FAIL rnd_shift r=%0d k=%0d got d%b c%0d s%0d exp d%b c%0d s%0d",
                             r, k, jp_data_out, read_cnt_out, state_out,
                             exp_line(v, k), exp_cnt(k), exp_state(k));
        end
      end
    end
  endtask

  task automatic test_latch_priority();
    logic [7:0] v1;
    logic [7:0] v2;
    v1 = 8'($urandom) & 8'hFE;
    v2 = ~v1;
    btn_in = v1;
    wait_cyc(SETTLE);
    latch_hi();
    latch_lo();
    for (int k = 1; k <= 3; k++) begin
      jclk_hi();
      jclk_lo();
    end
    btn_in = v2;
    wait_cyc(SETTLE);
    n_checks++;
    if (btn_state_out !== v2) begin
      n_fail++; $display("FAIL pri_btn got %h exp %h", btn_state_out, v2);
    end
    n_checks++;
    if (jp_data_out !== exp_line(v1, 3) || read_cnt_out !== 4'd3) begin
      n_fail++; $display("FAIL pri_hold got d%b c%0d exp d%b c3", jp_data_out, read_cnt_out, exp_line(v1, 3));
    end
    jp_latch_in = 1'b1;
    jp_clk_in   = 1'b1;
    wait_cyc(4);
    n_checks++;
    if (read_cnt_out !== 4'd0 || state_out !== 2'd1 || jp_data_out !== exp_line(v2, 0)) begin
      n_fail++; $display("FAIL pri_latch got c%0d s%0d d%b exp c0 s1 d%b",
                         read_cnt_out, state_out, jp_data_out, exp_line(v2, 0));
    end
    jp_latch_in = 1'b0;
    jp_clk_in   = 1'b0;
    wait_cyc(4);
    jclk_hi();
    jclk_lo();
    n_checks++;
    if (jp_data_out !== exp_line(v2, 1) || read_cnt_out !== 4'd1) begin
      n_fail++; $display("FAIL pri_after got d%b c%0d exp d%b c1", jp_data_out, read_cnt_out, exp_line(v2, 1));
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] v;
    v = 8'($urandom) | 8'h01;
    btn_in = v;
    wait_cyc(SETTLE);
    latch_hi();
    latch_lo();
    for (int k = 1; k <= 4; k++) begin
      jclk_hi();
      jclk_lo();
    end
    nrst_in = 1'b0;
    #1;
    n_checks++;
    if (jp_data_out !== (ALOW ? 1'b1 : 1'b0) || btn_state_out !== 8'h00 ||
        read_cnt_out !== 4'd0 || state_out !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid got d%b b%h c%0d s%0d exp d%b b00 c0 s0",
                         jp_data_out, btn_state_out, read_cnt_out, state_out, ALOW);
    end
    wait_cyc(2);
    nrst_in = 1'b1;
    wait_cyc(2);
    for (int k = 1; k <= 3; k++) begin
      jclk_hi();
      jclk_lo();
      n_checks++;
      if (state_out !== 2'd0 || read_cnt_out !== 4'd0 || jp_data_out !== (ALOW ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL rst_noshift k=%0d got s%0d c%0d d%b exp s0 c0 d%b",
                           k, state_out, read_cnt_out, jp_data_out, ALOW);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a_start_read();
    test_debounce();
    test_random_reads();
    test_latch_priority();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
